// File: rtl/xpb_pkg.sv
// Shared constants and state type for the xpb term accumulator.
// Optional feature macro: XPB_ACCUM_REDUNDANT_OUT_EN (see xpb_term_accum).
package xpb_pkg;

    localparam int unsigned XPB_WIDTH = 1024;
    localparam int unsigned XPB_GUARD = 10;
    localparam int unsigned XPB_SEG_W = 128;
    localparam int unsigned XPB_ACC_W = XPB_WIDTH + XPB_GUARD;

    function automatic int unsigned xpb_nseg(input int unsigned acc_w, input int unsigned seg_w);
        return (acc_w + seg_w - 1) / seg_w;
    endfunction

    localparam int unsigned XPB_NSEG = xpb_nseg(XPB_ACC_W, XPB_SEG_W);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        OUT
    } xpb_acc_state_t;

endpackage

// File: rtl/xpb_seg_cpa.sv
// Segmented carry-propagate adder: resolves a+b one SEG_W slice per cycle while run is high,
// pulsing done on the final slice. Carry out of the top slice is dropped.
module xpb_seg_cpa #(
    parameter int unsigned ACC_W = 1034,
    parameter int unsigned SEG_W = 128,
    parameter int unsigned NSEG  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             done
);

    localparam int unsigned PAD_W = NSEG * SEG_W;
    localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    logic [CNT_W-1:0] seg_q, seg_d;
    logic             cin_q, cin_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [PAD_W-1:0] a_pad, b_pad;
    logic [SEG_W-1:0] a_seg, b_seg;
    logic [SEG_W:0]   seg_sum;
    logic [ACC_W-1:0] seg_pos, seg_mask;

    always_comb begin
        a_pad    = PAD_W'(a);
        b_pad    = PAD_W'(b);
        a_seg    = '0;
        b_seg    = '0;
        seg_pos  = '0;
        seg_mask = '0;
        for (int unsigned i = 0; i < NSEG; i++) begin
            if (seg_q == CNT_W'(i)) begin
                a_seg = a_pad[i*SEG_W +: SEG_W];
                b_seg = b_pad[i*SEG_W +: SEG_W];
            end
        end
        seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cin_q};
        // Shifting inside ACC_W trims the short top slice for free.
        for (int unsigned i = 0; i < NSEG; i++) begin
            if (seg_q == CNT_W'(i)) begin
                seg_pos  = ACC_W'(seg_sum[SEG_W-1:0]) << (i * SEG_W);
                seg_mask = ACC_W'({SEG_W{1'b1}}) << (i * SEG_W);
            end
        end

        sum_d = sum_q;
        seg_d = seg_q;
        cin_d = cin_q;
        done  = 1'b0;
        if (run) begin
            sum_d = (sum_q & ~seg_mask) | seg_pos;
            if (seg_q == CNT_W'(NSEG - 1)) begin
                seg_d = '0;
                cin_d = 1'b0;
                done  = 1'b1;
            end else begin
                seg_d = seg_q + 1'b1;
                cin_d = seg_sum[SEG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            cin_q <= 1'b0;
            sum_q <= '0;
        end else begin
            seg_q <= seg_d;
            cin_q <= cin_d;
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/xpb_term_accum.sv
// Accumulates a packet of xpb terms in carry-save form and emits one resolved sum per packet.
// Define XPB_ACCUM_REDUNDANT_OUT_EN to skip resolution and expose sum/carry as res_data/res_carry.
module xpb_term_accum
    import xpb_pkg::*;
#(
    parameter int unsigned WIDTH = XPB_WIDTH,
    parameter int unsigned GUARD = XPB_GUARD,
    parameter int unsigned SEG_W = XPB_SEG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   term_valid,
    output logic                   term_ready,
    input  logic [WIDTH-1:0]       term_data,
    input  logic                   term_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH+GUARD-1:0] res_data,
`ifdef XPB_ACCUM_REDUNDANT_OUT_EN
    output logic [WIDTH+GUARD-1:0] res_carry,
`endif
    output logic [GUARD:0]         res_count
);

    localparam int unsigned ACC_W = WIDTH + GUARD;
    localparam int unsigned NSEG  = xpb_nseg(ACC_W, SEG_W);

    xpb_acc_state_t   state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d, c_q, c_d, t_ext;
    logic [GUARD:0]   cnt_q, cnt_d;
    logic             term_hs, res_hs, resolved;

`ifdef XPB_ACCUM_REDUNDANT_OUT_EN
    assign resolved  = 1'b1;
    assign res_data  = s_q;
    assign res_carry = c_q;
`else
    xpb_seg_cpa #(
        .ACC_W (ACC_W),
        .SEG_W (SEG_W),
        .NSEG  (NSEG)
    ) u_cpa (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == RESOLVE),
        .a     (s_q),
        .b     (c_q),
        .sum   (res_data),
        .done  (resolved)
    );
`endif

    always_comb begin
        t_ext      = ACC_W'(term_data);
        term_ready = rst_n && (state_q == IDLE || state_q == ACCUM);
        res_valid  = (state_q == OUT);
        term_hs    = term_valid & term_ready;
        res_hs     = res_valid & res_ready;

        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;

        if (term_hs) begin
            s_d   = s_q ^ c_q ^ t_ext;
            c_d   = ((s_q & c_q) | (s_q & t_ext) | (c_q & t_ext)) << 1;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
        if (res_hs) begin
            s_d   = '0;
            c_d   = '0;
            cnt_d = '0;
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (term_hs) begin
`ifdef XPB_ACCUM_REDUNDANT_OUT_EN
                    state_d = term_last ? OUT : ACCUM;
`else
                    state_d = term_last ? RESOLVE : ACCUM;
`endif
                end
            end
            RESOLVE: if (resolved) state_d = OUT;
            OUT:     if (res_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_count = cnt_q;

endmodule

// File: tb/tb_xpb_term_accum.sv
// Self-checking bench for xpb_term_accum: constant vector table, hand-written corner sequences
// and random packets checked against a plain-arithmetic sum model.
module tb_xpb_term_accum;

    localparam int W        = 1024;
    localparam int G        = 10;
    localparam int AW       = W + G;
    localparam int NSEG_EXP = (AW + 127) / 128;
    localparam int CNT_MAX  = (1 << (G + 1)) - 1;
`ifdef XPB_ACCUM_REDUNDANT_OUT_EN
    localparam int LAT_EXP = 1;
`else
    localparam int LAT_EXP = NSEG_EXP + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          term_valid, term_ready, term_last;
    logic [W-1:0]  term_data;
    logic          res_valid, res_ready;
    logic [AW-1:0] res_data;
    logic [G:0]    res_count;
    logic [AW-1:0] got_sum;

`ifdef XPB_ACCUM_REDUNDANT_OUT_EN
    logic [AW-1:0] res_carry;
    always_comb got_sum = res_data + res_carry;
`else
    always_comb got_sum = res_data;
`endif

    xpb_term_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_data  (term_data),
        .term_last  (term_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
`ifdef XPB_ACCUM_REDUNDANT_OUT_EN
        .res_carry  (res_carry),
`endif
        .res_count  (res_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [W-1:0] pkt_q[$];

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got hi=%h lo=%h, required hi=%h lo=%h",
                     name, got[AW-1:AW-16], got[63:0], exp[AW-1:AW-16], exp[63:0]);
        end
    endtask

    function automatic logic [AW-1:0] model_sum();
        logic [AW-1:0] acc = '0;
        foreach (pkt_q[i]) acc = acc + AW'(pkt_q[i]);
        return acc;
    endfunction

    function automatic int model_cnt();
        return (pkt_q.size() > CNT_MAX) ? CNT_MAX : pkt_q.size();
    endfunction

    function automatic logic [W-1:0] rand_term();
        logic [W-1:0] t;
        for (int k = 0; k < W / 32; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    // Called on a negedge; returns on the negedge right after the handshake edge.
    task automatic send_term(input logic [W-1:0] d, input logic l);
        int n = 0;
        term_valid = 1'b1;
        term_data  = d;
        term_last  = l;
        while (!term_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!term_ready) check("send_timeout", AW'(0), AW'(1));
        @(negedge clk);
        term_valid = 1'b0;
        term_last  = 1'b0;
    endtask

    task automatic send_packet(input bit gaps);
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            send_term(pkt_q[i], i == pkt_q.size() - 1);
        end
    endtask

    task automatic get_result(input string tag, input int ready_delay,
                              input logic [AW-1:0] exp_sum, input int exp_cnt);
        int lat = 1;
        bit unstable = 1'b0;
        logic [AW-1:0] d0;
        logic [G:0] c0;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) begin
            check({tag, ".valid_timeout"}, AW'(0), AW'(1));
            return;
        end
        check({tag, ".latency"}, AW'(lat), AW'(LAT_EXP));
        check({tag, ".data"}, got_sum, exp_sum);
        check({tag, ".count"}, AW'(res_count), AW'(exp_cnt));
        d0 = got_sum;
        c0 = res_count;
        for (int k = 0; k < ready_delay; k++) begin
            @(negedge clk);
            if (got_sum !== d0 || res_count !== c0 || !res_valid || term_ready) unstable = 1'b1;
        end
        if (ready_delay > 0) check({tag, ".hold_stable"}, AW'(unstable), AW'(0));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, ".post_hs"}, AW'({res_valid, term_ready}), AW'(2'b01));
    endtask

    typedef struct {
        logic [W-1:0]  t0, t1, t2;
        int            n;
        logic [AW-1:0] exp_sum;
        int            exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] ones;
        logic [AW-1:0] exp3;
        bit bad;
        int lat;

        ones = '1;
        exp3 = {8'b0, 1'b1, 1'b0, {1022{1'b1}}, 2'b01};
        vecs[0] = '{W'(32'h1234), '0, '0, 1, AW'(32'h1234), 1};
        vecs[1] = '{ones, ones, ones, 3, exp3, 3};
        vecs[2] = '{W'(5), W'(7), '0, 2, AW'(12), 2};
        vecs[3] = '{'0, '0, '0, 1, AW'(0), 1};
        vecs[4] = '{W'(1), W'(2), W'(3), 3, AW'(6), 3};

        rst_n = 1'b0; term_valid = 1'b0; term_last = 1'b0; term_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.ready_low", AW'(term_ready), AW'(0));
        check("rst.valid_low", AW'(res_valid), AW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.data", got_sum, AW'(0));
        check("rst.count", AW'(res_count), AW'(0));
        check("rst.ready_high", AW'({res_valid, term_ready}), AW'(2'b01));

        for (int v = 0; v < 5; v++) begin
            pkt_q = {};
            if (vecs[v].n > 0) pkt_q.push_back(vecs[v].t0);
            if (vecs[v].n > 1) pkt_q.push_back(vecs[v].t1);
            if (vecs[v].n > 2) pkt_q.push_back(vecs[v].t2);
            send_packet(1'b0);
            get_result($sformatf("vec%0d", v), 0, vecs[v].exp_sum, vecs[v].exp_cnt);
        end

        // Backpressure on the result, then immediate next packet.
        pkt_q = {W'(12'hABC), W'(12'h111)};
        send_packet(1'b0);
        get_result("hold", 5, AW'(12'hBCD), 2);
        pkt_q = {W'(42)};
        send_packet(1'b0);
        get_result("after_hold", 0, AW'(42), 1);

        // Term offered while resolving must wait for the next packet.
        send_term(W'(3), 1'b0);
        send_term(W'(4), 1'b1);
        term_valid = 1'b1; term_data = W'(9); term_last = 1'b1;
        bad = 1'b0; lat = 1;
        while (!res_valid && lat < 200) begin
            if (term_ready) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("busy.ready_low", AW'({bad, term_ready}), AW'(0));
        check("busy.data", got_sum, AW'(7));
        check("busy.count", AW'(res_count), AW'(2));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("busy.ready_back", AW'(term_ready), AW'(1));
        @(negedge clk);
        term_valid = 1'b0; term_last = 1'b0;
        get_result("busy_next", 0, AW'(9), 1);

        // Reset in the middle of a packet's resolution.
        send_term(W'(100), 1'b0);
        send_term(W'(200), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.ready_low", AW'({res_valid, term_ready}), AW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (NSEG_EXP + 4) begin
            @(negedge clk);
            if (res_valid) bad = 1'b1;
        end
        check("midrst.no_result", AW'(bad), AW'(0));
        check("midrst.count", AW'(res_count), AW'(0));
        pkt_q = {W'(5), W'(7)};
        send_packet(1'b0);
        get_result("midrst_next", 0, AW'(12), 2);

        // Random packets against the arithmetic model.
        for (int p = 0; p < 20; p++) begin
            int len = $urandom_range(1, 8);
            pkt_q = {};
            for (int i = 0; i < len; i++)
                pkt_q.push_back(($urandom_range(0, 4) == 0) ? ones : rand_term());
            send_packet(1'b1);
            get_result($sformatf("rand%0d", p), $urandom_range(0, 3), model_sum(), model_cnt());
        end

        // Guard-bit boundary and count saturation.
        pkt_q = {};
        repeat (1025) pkt_q.push_back(ones);
        send_packet(1'b0);
        get_result("guard1025", 0, model_sum(), 1025);
        pkt_q = {};
        repeat (2050) pkt_q.push_back(ones);
        send_packet(1'b0);
        get_result("sat2050", 0, model_sum(), CNT_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
